// File: rtl/keyboard_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_cmd_decoder_if
//  Description : Bundles the key-event input bus and the game-command output
//                bus of keyboard_cmd_decoder.
//                master : key-event source / command consumer (drives events)
//                slave  : the decoder (consumes events, drives commands)
//  Signals     : valid, makeBreak, outCode[7:0]       event side
//                enterEn, moveRightEn, moveLeftEn,
//                moveUpEn, moveDownEn, keyHeld[4:0]    command side
//  Revision    : 1.0  initial release
// ============================================================================
interface keyboard_cmd_decoder_if;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       enterEn;
    logic       moveRightEn;
    logic       moveLeftEn;
    logic       moveUpEn;
    logic       moveDownEn;
    logic [4:0] keyHeld;

    modport master (
        output valid, makeBreak, outCode,
        input  enterEn, moveRightEn, moveLeftEn, moveUpEn, moveDownEn, keyHeld
    );

    modport slave (
        input  valid, makeBreak, outCode,
        output enterEn, moveRightEn, moveLeftEn, moveUpEn, moveDownEn, keyHeld
    );
endinterface
`default_nettype wire

// File: rtl/keyboard_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_cmd_decoder
//  Description : Converts decoded PS/2 key events into one-cycle game command
//                pulses. Detects the rising edge of valid, tracks which mapped
//                keys are held, swallows keyboard typematic resends and,
//                optionally, generates its own auto-repeat on held keys.
//  Macro       : KBD_AUTO_REPEAT_EN - builds the auto-repeat FSM and counter.
//  Ports       : clk     system clock
//                resetn  synchronous active-low reset
//                bus     keyboard_cmd_decoder_if.slave (events in, pulses and
//                        keyHeld out; bit order {down,up,left,right,enter})
//  Revision    : 1.0  initial release
// ============================================================================
module keyboard_cmd_decoder #(
    parameter int         REPEAT_DELAY  = 25_000_000,
    parameter int         REPEAT_PERIOD = 5_000_000,
    parameter logic [4:0] REPEAT_MASK   = 5'b11110
) (
    input  wire logic                    clk,
    input  wire logic                    resetn,
    keyboard_cmd_decoder_if.slave        bus
);

    logic       r_validQ;
    logic [4:0] r_keyHeld;
    logic [4:0] r_pulse;

    logic       w_event;
    logic       w_mapped;
    logic [2:0] w_idx;
    logic [4:0] w_keyBit;
    logic [4:0] w_press;
    logic [4:0] w_release;
    logic [4:0] w_rptOneHot;

    // r_validQ resets to 1 so a valid already high at reset release is not
    // mistaken for a fresh event.
    assign w_event = bus.valid & ~r_validQ;

    always_comb begin
        w_mapped = 1'b1;
        w_idx    = 3'd0;
        case (bus.outCode)
            8'h5A:   w_idx = 3'd0;
            8'h74:   w_idx = 3'd1;
            8'h6B:   w_idx = 3'd2;
            8'h75:   w_idx = 3'd3;
            8'h72:   w_idx = 3'd4;
            default: w_mapped = 1'b0;
        endcase
    end

    assign w_keyBit  = w_mapped ? (5'b00001 << w_idx) : 5'b00000;
    // A make of an already-held key is a typematic resend: masked out here.
    assign w_press   = (w_event &  bus.makeBreak) ? (w_keyBit & ~r_keyHeld) : 5'b00000;
    assign w_release = (w_event & ~bus.makeBreak) ? (w_keyBit &  r_keyHeld) : 5'b00000;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_validQ  <= 1'b1;
            r_keyHeld <= 5'b00000;
            r_pulse   <= 5'b00000;
        end else begin
            r_validQ  <= bus.valid;
            r_keyHeld <= (r_keyHeld | w_press) & ~w_release;
            r_pulse   <= w_press | w_rptOneHot;
        end
    end

`ifdef KBD_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    localparam int c_CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_DELAY_LAST  = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_PERIOD_LAST = c_CNT_W'(REPEAT_PERIOD - 1);

    state_t               r_state, w_stateNext;
    logic [2:0]           r_rptIdx, w_rptIdxNext;
    logic [c_CNT_W-1:0]   r_cnt, w_cntNext;
    logic [4:0]           w_maskedPress;

    assign w_maskedPress = w_press & REPEAT_MASK;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_rptIdx <= 3'd0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_rptIdx <= w_rptIdxNext;
            r_cnt    <= w_cntNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_rptIdxNext = r_rptIdx;
        w_cntNext    = r_cnt;
        w_rptOneHot  = 5'b00000;
        if (|w_maskedPress) begin
            // Newest masked key takes over the repeat slot from any state.
            w_stateNext  = S_DELAY;
            w_rptIdxNext = w_idx;
            w_cntNext    = '0;
        end else if ((r_state != S_IDLE) && w_release[r_rptIdx]) begin
            w_stateNext = S_IDLE;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                S_DELAY: begin
                    if (r_cnt == c_DELAY_LAST) begin
                        w_rptOneHot = 5'b00001 << r_rptIdx;
                        w_cntNext   = '0;
                        w_stateNext = S_REPEAT;
                    end else begin
                        w_cntNext = r_cnt + c_CNT_W'(1);
                    end
                end
                S_REPEAT: begin
                    if (r_cnt == c_PERIOD_LAST) begin
                        w_rptOneHot = 5'b00001 << r_rptIdx;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    w_stateNext = S_IDLE;
                    w_cntNext   = '0;
                end
            endcase
        end
    end
`else
    assign w_rptOneHot = 5'b00000;
`endif

    assign bus.enterEn     = r_pulse[0];
    assign bus.moveRightEn = r_pulse[1];
    assign bus.moveLeftEn  = r_pulse[2];
    assign bus.moveUpEn    = r_pulse[3];
    assign bus.moveDownEn  = r_pulse[4];
    assign bus.keyHeld     = r_keyHeld;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keyboard_cmd_decoder
//  Description : Self-checking bench for keyboard_cmd_decoder. Directed key
//                scenarios followed by random event traffic; every cycle the
//                pulse outputs and keyHeld are compared with a reference model
//                that tracks held keys and absolute repeat due-times.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keyboard_cmd_decoder;

    localparam int         c_DELAY  = 8;
    localparam int         c_PERIOD = 4;
    localparam logic [4:0] c_MASK   = 5'b11110;

    logic clk;
    logic resetn;
    keyboard_cmd_decoder_if kbdBus();

    keyboard_cmd_decoder #(
        .REPEAT_DELAY  (c_DELAY),
        .REPEAT_PERIOD (c_PERIOD),
        .REPEAT_MASK   (c_MASK)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (kbdBus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, mEdge);
    endtask

    // ---------------- reference model ----------------
    logic       mValidPrev = 1'b1;
    logic [4:0] mHeld      = '0;
    logic [4:0] mExpPulse  = '0;
    bit         mRptOn     = 0;
    int         mRptKey    = 0;
    longint     mDue       = 0;
    longint     mEdge      = 0;

    function automatic int keyIndex(input logic [7:0] code);
        case (code)
            8'h5A:   return 0;
            8'h74:   return 1;
            8'h6B:   return 2;
            8'h75:   return 3;
            8'h72:   return 4;
            default: return -1;
        endcase
    endfunction

    task automatic modelEdge(input logic rn, input logic v, input logic mb, input logic [7:0] code);
        bit ev;
        bit rearmed;
        int k;
        mEdge++;
        mExpPulse = '0;
        if (!rn) begin
            mHeld = '0; mValidPrev = 1'b1; mRptOn = 0;
            return;
        end
        ev = v && !mValidPrev;
        mValidPrev = v;
        k = keyIndex(code);
        rearmed = 0;
        if (ev && k >= 0) begin
            if (mb && !mHeld[k]) begin
                mExpPulse[k] = 1'b1;
                mHeld[k] = 1'b1;
`ifdef KBD_AUTO_REPEAT_EN
                if (c_MASK[k]) begin
                    mRptOn = 1; mRptKey = k; mDue = mEdge + c_DELAY; rearmed = 1;
                end
`endif
            end else if (!mb && mHeld[k]) begin
                mHeld[k] = 1'b0;
                if (mRptOn && mRptKey == k) mRptOn = 0;
            end
        end
`ifdef KBD_AUTO_REPEAT_EN
        if (mRptOn && !rearmed && mEdge == mDue) begin
            mExpPulse[mRptKey] = 1'b1;
            mDue = mEdge + c_PERIOD;
        end
`endif
    endtask

    // ---------------- stimulus ----------------
    logic curValid = 1'b1;

    task automatic step(input logic rn, input logic v, input logic mb, input logic [7:0] code);
        logic [4:0] gotPulse;
        @(negedge clk);
        resetn = rn;
        kbdBus.valid = v;
        kbdBus.makeBreak = mb;
        kbdBus.outCode = code;
        curValid = v;
        @(posedge clk);
        modelEdge(rn, v, mb, code);
        #1;
        gotPulse = {kbdBus.moveDownEn, kbdBus.moveUpEn, kbdBus.moveLeftEn,
                    kbdBus.moveRightEn, kbdBus.enterEn};
        checkEq("pulses", {3'b000, gotPulse}, {3'b000, mExpPulse});
        checkEq("keyHeld", {3'b000, kbdBus.keyHeld}, {3'b000, mHeld});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, curValid, kbdBus.makeBreak, kbdBus.outCode);
    endtask

    task automatic keyEvent(input logic mb, input logic [7:0] code);
        step(1'b1, 1'b0, mb, code);
        step(1'b1, 1'b1, mb, code);
    endtask

    logic [7:0] codes [6];

    initial begin
        codes[0] = 8'h5A; codes[1] = 8'h74; codes[2] = 8'h6B;
        codes[3] = 8'h75; codes[4] = 8'h72; codes[5] = 8'h1C;
        resetn = 1'b0;
        kbdBus.valid = 1'b1;
        kbdBus.makeBreak = 1'b1;
        kbdBus.outCode = 8'h5A;

        // Reset with valid already high: no spurious event afterwards.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'h5A);
        idle(20);

        // Enter press, valid held, then release.
        keyEvent(1'b1, 8'h5A);
        idle(10);
        keyEvent(1'b0, 8'h5A);

        // Right press plus three typematic resends, then break.
        keyEvent(1'b1, 8'h74);
        for (int i = 0; i < 3; i++) keyEvent(1'b1, 8'h74);
        idle(2);
        keyEvent(1'b0, 8'h74);

        // Up held through first repeats, released before the third.
        keyEvent(1'b1, 8'h75);
        idle(12);
        keyEvent(1'b0, 8'h75);
        idle(6);

        // Left held, down pressed after first repeat, left released.
        keyEvent(1'b1, 8'h6B);
        idle(10);
        keyEvent(1'b1, 8'h72);
        idle(12);
        keyEvent(1'b0, 8'h6B);
        idle(10);
        keyEvent(1'b0, 8'h72);

        // Unmapped make and break of an unheld key.
        keyEvent(1'b1, 8'h1C);
        keyEvent(1'b0, 8'h72);
        idle(3);

        // Reset while repeating.
        keyEvent(1'b1, 8'h75);
        idle(12);
        step(1'b0, 1'b1, 1'b1, 8'h75);
        idle(12);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic v;
            logic mb;
            logic [7:0] code;
            logic rn;
            int sel;
            v = curValid;
            if ($urandom_range(0, 5) == 0) v = ~v;
            mb = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 6);
            code = (sel == 6) ? 8'($urandom) : codes[sel];
            rn = ($urandom_range(0, 299) != 0);
            step(rn, v, mb, code);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
